// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector with a 2-entry skid buffer and valid/ready handshakes.
// Optional zero/negative result flags are enabled with macro ALU_RESULT_SEL_FLAGS_EN.
module alu_result_sel_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef ALU_RESULT_SEL_FLAGS_EN
  ,
  output logic                    out_zero,
  output logic                    out_neg
`endif
);

`ifdef ALU_RESULT_SEL_FLAGS_EN
  localparam int PW = WIDTH + 3;
`else
  localparam int PW = WIDTH + 1;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [PW-1:0]   r_main_pl;
  logic [PW-1:0]   r_skid_pl;
  logic [PW-1:0]   w_new_pl;
  logic [WIDTH-1:0] w_sel_data;
  logic            w_hit;
  logic            w_accept;
  logic            w_pop;
  logic            w_load_main;
  logic            w_load_skid;
  logic            w_main_from_skid;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  // An unmatched select (only reachable when NUM_IN is not a power of 2) yields zero data and no hit.
  always_comb begin
    w_sel_data = '0;
    w_hit      = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_hit      = w_hit | (sel == SEL_W'(i));
      w_sel_data = w_sel_data | ({WIDTH{sel == SEL_W'(i)}} & in_bus[i*WIDTH +: WIDTH]);
    end
  end

`ifdef ALU_RESULT_SEL_FLAGS_EN
  assign w_new_pl = {w_sel_data[WIDTH-1], (w_sel_data == '0), ~w_hit, w_sel_data};
`else
  assign w_new_pl = {~w_hit, w_sel_data};
`endif

  // Next-state and storage-steering decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end else begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end else begin
          w_state_nxt = S_ONE;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt      = S_ONE;
          w_main_from_skid = 1'b1;
        end else begin
          w_state_nxt = S_FULL;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // State, registered ready and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  // Payload registers load only on accept or skid-to-main move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_pl <= '0;
      r_skid_pl <= '0;
    end else begin
      if (w_load_main) begin
        r_main_pl <= w_new_pl;
      end else if (w_main_from_skid) begin
        r_main_pl <= r_skid_pl;
      end
      if (w_load_skid) begin
        r_skid_pl <= w_new_pl;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_main_pl[WIDTH-1:0];
  assign out_sel_err = r_main_pl[WIDTH];
`ifdef ALU_RESULT_SEL_FLAGS_EN
  assign out_zero    = r_main_pl[WIDTH+1];
  assign out_neg     = r_main_pl[WIDTH+2];
`endif

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Bench for alu_result_sel_pipe: two instances (NUM_IN = 8 and 6) against a queue-based
// reference model, plus directed literal checks. Honours ALU_RESULT_SEL_FLAGS_EN.
module tb_alu_result_sel_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        zero;
    logic        neg;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] in_bus;
  logic [2:0]   sel;
  logic         in_valid;
  logic         out_ready;
  logic         rdy8, vld8, err8, z8, n8;
  logic         rdy6, vld6, err6, z6, n6;
  logic [31:0]  d8, d6;

  int    vectors     = 0;
  int    miscompares = 0;
  item_t mq[2][$];
  bit    m_ready[2];
  int    ni[2] = '{8, 6};

  always #5 clk = ~clk;

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(rdy8), .out_data(d8), .out_sel_err(err8), .out_valid(vld8), .out_ready(out_ready)
`ifdef ALU_RESULT_SEL_FLAGS_EN
    , .out_zero(z8), .out_neg(n8)
`endif
  );

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus[191:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(rdy6), .out_data(d6), .out_sel_err(err6), .out_valid(vld6), .out_ready(out_ready)
`ifdef ALU_RESULT_SEL_FLAGS_EN
    , .out_zero(z6), .out_neg(n6)
`endif
  );

`ifndef ALU_RESULT_SEL_FLAGS_EN
  assign z8 = 1'b0;
  assign n8 = 1'b0;
  assign z6 = 1'b0;
  assign n6 = 1'b0;
`endif

  function automatic item_t model_item(int n, logic [255:0] bus, logic [2:0] s);
    item_t it;
    if (int'(s) < n) begin
      it.data = bus[int'(s)*32 +: 32];
      it.err  = 1'b0;
    end else begin
      it.data = 32'h0000_0000;
      it.err  = 1'b1;
    end
    it.zero = (it.data == 32'h0000_0000);
    it.neg  = it.data[31];
    return it;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic v, logic r, logic [31:0] d, logic e, logic z, logic n);
    bit ev;
    ev = (mq[k].size() > 0);
    check($sformatf("in_ready[%0d]", ni[k]), {31'd0, r}, {31'd0, m_ready[k]});
    check($sformatf("out_valid[%0d]", ni[k]), {31'd0, v}, {31'd0, ev});
    if (ev) begin
      check($sformatf("out_data[%0d]", ni[k]), d, mq[k][0].data);
      check($sformatf("out_sel_err[%0d]", ni[k]), {31'd0, e}, {31'd0, mq[k][0].err});
`ifdef ALU_RESULT_SEL_FLAGS_EN
      check($sformatf("out_zero[%0d]", ni[k]), {31'd0, z}, {31'd0, mq[k][0].zero});
      check($sformatf("out_neg[%0d]", ni[k]), {31'd0, n}, {31'd0, mq[k][0].neg});
`endif
    end
  endtask

  // Reference model: a capacity-2 FIFO; ready is "not full after this edge".
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit acc;
      bit pop;
      if (!rst_n) begin
        mq[k].delete();
        m_ready[k] = 1'b0;
      end else begin
        acc = in_valid && m_ready[k];
        pop = (mq[k].size() > 0) && out_ready;
        if (pop) void'(mq[k].pop_front());
        if (acc) mq[k].push_back(model_item(ni[k], in_bus, sel));
        m_ready[k] = (mq[k].size() != 2);
      end
    end
  end

  always @(negedge clk) begin
    cmp(0, vld8, rdy8, d8, err8, z8, n8);
    cmp(1, vld6, rdy6, d6, err6, z6, n6);
  end

  initial begin
    int mode;
    logic [31:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_bus[i*32 +: 32] = 32'h1000_0000 + 32'(i);

    // Reset held with in_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", {31'd0, vld8}, 32'd0);
      check("rst_ready", {31'd0, rdy8}, 32'd0);
      check("rst_data", d8, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, rdy8}, 32'd1);
    check("post_rst_valid", {31'd0, vld8}, 32'd0);

    // Streaming sel = 0..7, then sel = 5 on the 6-input instance
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      sel = (k == 8) ? 3'd5 : 3'(k);
      @(negedge clk);
      check("stream_data8", d8, 32'h1000_0000 + 32'(sel));
      check("stream_ready8", {31'd0, rdy8}, 32'd1);
      check("oor_data6", d6, (k == 6 || k == 7) ? 32'h0 : 32'h1000_0000 + 32'(sel));
      check("oor_err6", {31'd0, err6}, (k == 6 || k == 7) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: A, B accepted, C held until drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd1;
    @(negedge clk);
    check("bp_A_ready", {31'd0, rdy8}, 32'd1);
    sel = 3'd2;
    @(negedge clk);
    check("bp_full_ready", {31'd0, rdy8}, 32'd0);
    sel = 3'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_data", d8, 32'h1000_0001);
      check("bp_stall_ready", {31'd0, rdy8}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_B", d8, 32'h1000_0002);
    @(negedge clk);
    check("bp_C", d8, 32'h1000_0003);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", {31'd0, vld8}, 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd4;
    @(negedge clk);
    sel = 3'd5;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, vld8}, 32'd0);
    check("midrst_ready", {31'd0, rdy8}, 32'd0);
    rst_n = 1'b1;
    sel   = 3'd6;
    @(negedge clk);
    check("midrst_ready_up", {31'd0, rdy8}, 32'd1);
    @(negedge clk);
    check("midrst_first_item", d8, 32'h1000_0006);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

`ifdef ALU_RESULT_SEL_FLAGS_EN
    // Flags: zero, negative, positive
    in_bus[31:0]  = 32'h0000_0000;
    in_bus[63:32] = 32'h8000_0000;
    in_bus[95:64] = 32'h0000_0001;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = 3'(k);
      @(negedge clk);
      check("flag_zero", {31'd0, z8}, (k == 0) ? 32'd1 : 32'd0);
      check("flag_neg", {31'd0, n8}, (k == 1) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
`endif

    // Randomized traffic with varying backpressure and occasional reset
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) mode = int'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 7));
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, mode) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: v = 32'h0000_0000;
          1: v = {1'b1, 31'($urandom)};
          default: v = $urandom;
        endcase
        in_bus[i*32 +: 32] = v;
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
